cond_logic: RTL
===============

# cond_logic

Conditional-execution unit for the single-cycle ARM datapath, directly downstream of the 32-bit ALU. Latches the ALU's N/Z/C/V flags into an architectural flag register under instruction control. Evaluates the instruction's 4-bit condition field against the stored flags. Gates the decoder's PC, register-file and memory write strobes so that a failed condition leaves no architectural side effect.

## Interface
Parameters:
- FLAG_RESET, 4'b0000: reset value of the flag register, ordered {N,Z,C,V}.
- COND_NV_EXEC, 0: condition code 4'b1111 fails when 0, passes when 1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- Cond  input  4  condition field, Instr[31:28].
- FlagW  input  2  flag write request: bit 1 updates N,Z; bit 0 updates C,V.
- PCS  input  1  decoder request to write the PC (branch, or Rd==R15).
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  suppress register write (CMP/CMN/TST/TEQ).
- PCSrc  output  1  gated PC-write select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated data-memory write enable.
- CondEx  output  1  condition passed.
- Flags  output  4  current registered {N,Z,C,V}.

## Operation
- Flag register: two independent 2-bit registers, NZ = Flags[3:2] and CV = Flags[1:0].
- Condition evaluation is combinational on the registered Flags, never on ALUFlags. Pass conditions by Cond value:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: the value of COND_NV_EXEC.
- Gated strobes:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
- Flag writes:
  - FlagWrite[1] = FlagW[1] & CondEx; FlagWrite[0] = FlagW[0] & CondEx.
  - At each rising clk: if FlagWrite[1], NZ <= ALUFlags[3:2]; if FlagWrite[0], CV <= ALUFlags[1:0].
  - A register whose enable is low holds its value.
- A failed condition blocks all three strobes and both flag writes.
- FlagW = 2'b10 (logical op with S) updates N,Z and preserves C,V.

## Timing
- Reset:
  - reset_n low immediately sets Flags = FLAG_RESET, asynchronously and without waiting for clk.
  - While reset_n is low, CondEx, PCSrc, RegWrite and MemWrite are forced to 0 regardless of inputs.
  - Release is synchronised by the system. The first edge after release may update flags normally.
- Latency:
  - CondEx and the strobes are combinational, settling in the same cycle as Cond, PCS, RegW, MemW and NoWrite.
  - Flags changes one cycle after the instruction that sets them.
  - An instruction that sets flags and is itself conditional is evaluated against the old flags.
  - The next instruction sees the new flags.
- Simultaneous events:
  - Both FlagW bits set with CondEx=1: all four flags update on the same edge.
  - reset_n asserted on the same edge as a flag write: reset wins.
- ALUFlags is sampled only at the clk edge. Glitches between edges have no effect.

## Test plan
- Reset: hold reset_n=0 with Cond=1110, PCS=RegW=MemW=1 -> Flags=4'b0000, CondEx=0, all strobes 0. Release -> CondEx=1, PCSrc=RegWrite=MemWrite=1.
- Flag latch and EQ: ALUFlags=4'b0100, FlagW=11, Cond=1110, clock -> Flags=0100. Then Cond=0000, RegW=1 -> CondEx=1, RegWrite=1. Then Cond=0001 -> CondEx=0, RegWrite=0.
- Partial update: Flags=0011, ALUFlags=1000, FlagW=10, clock -> Flags=1011 (C,V preserved).
- Suppressed instruction: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0. Clock -> Flags still 0000.
- Signed conditions: sweep all 16 flag values across Cond 1010-1101 and 1000-1001; CondEx must match the table above. Example: Flags=1000 -> GE=0, LT=1, GT=0, LE=1.
- CMP path: Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 -> RegWrite=0, CondEx=1. Clock -> Flags=0110.

Source files
------------

// File: rtl/cond_logic.sv
// Conditional-execution unit that sits after the ALU.
// Holds the architectural N/Z/C/V flags, evaluates the instruction condition
// against them and gates the decoder write strobes. A failed condition leaves
// no side effect.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET   = 4'b0000,
  parameter logic       COND_NV_EXEC = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  // NZ and CV are separate registers so a logical op with S can update N,Z
  // and leave C,V alone.
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic [1:0] flag_write;
  logic       cond_pass;

  // Evaluate an ARM condition code against a {N,Z,C,V} flag set.
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = COND_NV_EXEC;
    endcase
    return res;
  endfunction

  // Condition check on the registered flags only; everything is held off
  // while reset is asserted.
  always_comb begin
    cond_pass  = eval_cond(Cond, {nz_q, cv_q}) & reset_n;
    flag_write = FlagW & {2{cond_pass}};
    CondEx     = cond_pass;
    PCSrc      = PCS & cond_pass;
    RegWrite   = RegW & cond_pass & ~NoWrite;
    MemWrite   = MemW & cond_pass;
    Flags      = {nz_q, cv_q};
  end

  // Next-state for the two flag halves: load from the ALU when enabled, else hold.
  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (flag_write[1]) nz_d = ALUFlags[3:2];
    if (flag_write[0]) cv_d = ALUFlags[1:0];
  end

  // Flag register with asynchronous reset to FLAG_RESET.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nz_q <= FLAG_RESET[3:2];
      cv_q <= FLAG_RESET[1:0];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

endmodule
